// File: rtl/sram_responder_if.sv
// ---------------------------------------------------------------------------
// sram_responder_if
// Control pins of the 16-bit asynchronous SRAM interface, as driven by an
// SRAM controller and observed by the memory-side responder.
//
// Signals:
//   SRAM_ADDR  18  halfword address
//   SRAM_UB_N   1  high-byte mask, active-low
//   SRAM_LB_N   1  low-byte mask, active-low
//   SRAM_WE_N   1  write enable, active-low
//   SRAM_CE_N   1  chip enable, active-low
//   SRAM_OE_N   1  output enable, active-low
//
// The bidirectional data bus SRAM_DQ is not part of this bundle: it is a
// resolved tristate net and is carried as a plain inout port so that its
// drivers are resolved on a single net at the level that instantiates the
// responder.
//
// Modports:
//   master  controller side (drives every pin)
//   slave   memory side (samples every pin)
// ---------------------------------------------------------------------------
interface sram_responder_if;
   logic [17:0] SRAM_ADDR;
   logic        SRAM_UB_N;
   logic        SRAM_LB_N;
   logic        SRAM_WE_N;
   logic        SRAM_CE_N;
   logic        SRAM_OE_N;

   modport master (
      output SRAM_ADDR,
      output SRAM_UB_N,
      output SRAM_LB_N,
      output SRAM_WE_N,
      output SRAM_CE_N,
      output SRAM_OE_N
   );

   modport slave (
      input SRAM_ADDR,
      input SRAM_UB_N,
      input SRAM_LB_N,
      input SRAM_WE_N,
      input SRAM_CE_N,
      input SRAM_OE_N
   );
endinterface

// File: rtl/sram_responder.sv
// ---------------------------------------------------------------------------
// sram_responder
// Memory-side model of a 16-bit asynchronous SRAM, usable in simulation and
// in FPGA loopback builds. Stores data with byte masks, returns read data
// after a programmable number of clock edges, counts accesses and keeps a
// sticky protocol-error flag.
//
// Parameters:
//   AW        address width; array depth is 2**AW halfwords
//   READ_LAT  posedges from first sampled read to data on DQ (1..7)
//   CNT_W     width of the access counters
//
// Ports:
//   clk        clock; every pin is sampled on its rising edge
//   rst        asynchronous reset, active-low
//   sram       control pins (slave modport of sram_responder_if)
//   SRAM_DQ    bidirectional data bus; driven only while presenting read data
//   rd_count   completed reads, wraps
//   wr_count   write cycles sampled, wraps
//   busy       high while a read is waiting or being presented
//   proto_err  sticky protocol violation flag
// ---------------------------------------------------------------------------
module sram_responder #(
   parameter int AW       = 18,
   parameter int READ_LAT = 2,
   parameter int CNT_W    = 16
) (
   input  logic             clk,
   input  logic             rst,
   sram_responder_if.slave  sram,
   inout  wire  [15:0]      SRAM_DQ,
   output logic [CNT_W-1:0] rd_count,
   output logic [CNT_W-1:0] wr_count,
   output logic             busy,
   output logic             proto_err
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      RD_WAIT  = 2'd1,
      RD_DRIVE = 2'd2
   } state_t;

   // The edge that starts a read already counts as the first latency edge.
   localparam logic [2:0] LAT_LOAD = 3'(READ_LAT - 1);

   logic [15:0]      r_mem [0:(2**AW)-1];
   state_t           r_state;
   state_t           w_nextState;
   logic [2:0]       r_cnt;
   logic [AW-1:0]    r_rdAddr;
   logic [15:0]      r_rdData;
   logic             r_drive;
   logic             r_busy;
   logic [CNT_W-1:0] r_rdCount;
   logic [CNT_W-1:0] r_wrCount;
   logic             r_protoErr;

   logic [AW-1:0]    w_addr;
   logic             w_wr;
   logic             w_rd;
   logic             w_sameAddr;
   logic             w_start;
   logic             w_loadCnt;
   logic             w_decCnt;
   logic             w_rdDone;
   logic             w_protoViol;

   // Upper address bits are ignored, so out-of-range addresses alias.
   assign w_addr     = sram.SRAM_ADDR[AW-1:0];
   assign w_wr       = !sram.SRAM_CE_N && !sram.SRAM_WE_N;
   assign w_rd       = !sram.SRAM_CE_N &&  sram.SRAM_WE_N && !sram.SRAM_OE_N;
   assign w_sameAddr = (w_addr == r_rdAddr);

   // Contention risk, or an access that selects neither byte lane.
   assign w_protoViol = (!sram.SRAM_CE_N && !sram.SRAM_WE_N && !sram.SRAM_OE_N)
                     || ((w_wr || w_rd) && sram.SRAM_UB_N && sram.SRAM_LB_N);

   // Read sequencing. A read (re)starts whenever one is sampled at an address
   // other than the one being served; a write always falls through to IDLE
   // because it can never also decode as a read.
   always_comb begin
      w_nextState = r_state;
      w_start     = 1'b0;
      w_loadCnt   = 1'b0;
      w_decCnt    = 1'b0;
      w_rdDone    = 1'b0;
      case (r_state)
         IDLE: begin
            w_start = w_rd;
         end
         RD_WAIT: begin
            if (!w_rd) begin
               w_nextState = IDLE;
            end else if (!w_sameAddr) begin
               w_start = 1'b1;
            end else if (r_cnt == 3'd1) begin
               w_nextState = RD_DRIVE;
               w_rdDone    = 1'b1;
            end else begin
               w_decCnt = 1'b1;
            end
         end
         RD_DRIVE: begin
            if (!w_rd) begin
               w_nextState = IDLE;
            end else if (!w_sameAddr) begin
               w_start = 1'b1;
            end
         end
         default: begin
            w_nextState = IDLE;
         end
      endcase
      if (w_start) begin
         if (READ_LAT == 1) begin
            w_nextState = RD_DRIVE;
            w_rdDone    = 1'b1;
         end else begin
            w_nextState = RD_WAIT;
            w_loadCnt   = 1'b1;
         end
      end
   end

   // State, latency counter and captured address. The DQ output enable and
   // busy are registered from the next state so the bus is never turned
   // around combinationally by a pin change.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state  <= IDLE;
         r_cnt    <= '0;
         r_rdAddr <= '0;
         r_drive  <= 1'b0;
         r_busy   <= 1'b0;
      end else begin
         r_state <= w_nextState;
         if (w_loadCnt) begin
            r_cnt <= LAT_LOAD;
         end else if (w_decCnt) begin
            r_cnt <= r_cnt - 3'd1;
         end
         if (w_start) begin
            r_rdAddr <= w_addr;
         end
         r_drive <= (w_nextState == RD_DRIVE);
         r_busy  <= (w_nextState != IDLE);
      end
   end

   // Access counters wrap silently; the error flag only clears on reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_rdCount  <= '0;
         r_wrCount  <= '0;
         r_protoErr <= 1'b0;
      end else begin
         if (w_rdDone) begin
            r_rdCount <= r_rdCount + CNT_W'(1);
         end
         if (w_wr) begin
            r_wrCount <= r_wrCount + CNT_W'(1);
         end
         if (w_protoViol) begin
            r_protoErr <= 1'b1;
         end
      end
   end

   // Storage is deliberately outside reset so contents survive it. Read data
   // is captured on the edge that enters RD_DRIVE, which is never a write
   // edge, so a following write does not disturb the data being presented.
   always_ff @(posedge clk) begin
      if (w_wr && !sram.SRAM_UB_N) begin
         r_mem[w_addr][15:8] <= SRAM_DQ[15:8];
      end
      if (w_wr && !sram.SRAM_LB_N) begin
         r_mem[w_addr][7:0] <= SRAM_DQ[7:0];
      end
      if (w_rdDone) begin
         r_rdData <= r_mem[w_addr];
      end
   end

   // Byte lanes follow the live mask pins so a controller can release a lane
   // mid-read without waiting for a clock edge.
   assign SRAM_DQ[15:8] = (r_drive && !sram.SRAM_UB_N) ? r_rdData[15:8] : 8'bz;
   assign SRAM_DQ[7:0]  = (r_drive && !sram.SRAM_LB_N) ? r_rdData[7:0]  : 8'bz;

   assign rd_count  = r_rdCount;
   assign wr_count  = r_wrCount;
   assign busy      = r_busy;
   assign proto_err = r_protoErr;

endmodule

// File: tb/tb_sram_responder.sv
// ---------------------------------------------------------------------------
// tb_sram_responder
// Self-checking bench for sram_responder (AW=18, READ_LAT=2, CNT_W=16).
// A transaction-level model tracks memory contents and how many consecutive
// edges the same read has been held; a compare process checks every output
// against it on each falling edge, and the directed sequence adds literal
// expectations at the interesting points.
// ---------------------------------------------------------------------------
module tb_sram_responder;

   localparam int LAT     = 2;
   localparam int CMD_NOP = 0;
   localparam int CMD_WR  = 1;
   localparam int CMD_RD  = 2;
   localparam int CMD_BAD = 3;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   sram_responder_if sramBus();

   wire  [15:0] SRAM_DQ;
   logic        tbDqEn;
   logic [15:0] tbDqOut;

   assign SRAM_DQ = tbDqEn ? tbDqOut : 16'bz;

   logic [15:0] rdCount;
   logic [15:0] wrCount;
   logic        busy;
   logic        protoErr;

   sram_responder #(
      .AW(18),
      .READ_LAT(LAT),
      .CNT_W(16)
   ) dut (
      .clk(clk),
      .rst(rst),
      .sram(sramBus),
      .SRAM_DQ(SRAM_DQ),
      .rd_count(rdCount),
      .wr_count(wrCount),
      .busy(busy),
      .proto_err(protoErr)
   );

   int checks   = 0;
   int failures = 0;

   // One comparison; any difference, including X or Z bits, is a failure.
   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   // A released byte lane reads as 00 so it can be compared like data; every
   // value the bench reads back has non-zero bytes in the lanes it checks.
   function automatic logic [15:0] normDq(input logic [15:0] v);
      logic [15:0] r;
      r = v;
      if (v[15:8] === 8'hzz) r[15:8] = 8'h00;
      if (v[7:0] === 8'hzz)  r[7:0]  = 8'h00;
      return r;
   endfunction

   // Sets the pins for one command and lets exactly one rising edge sample
   // it; returns 2 time units after that edge with the pins still applied.
   task automatic applyStimulus(input int cmd, input logic [17:0] addr,
                                input logic [15:0] data, input logic ub,
                                input logic lb);
      sramBus.SRAM_ADDR = addr;
      sramBus.SRAM_UB_N = ub;
      sramBus.SRAM_LB_N = lb;
      tbDqOut           = data;
      case (cmd)
         CMD_WR: begin
            sramBus.SRAM_CE_N = 1'b0; sramBus.SRAM_WE_N = 1'b0;
            sramBus.SRAM_OE_N = 1'b1; tbDqEn = 1'b1;
         end
         CMD_RD: begin
            sramBus.SRAM_CE_N = 1'b0; sramBus.SRAM_WE_N = 1'b1;
            sramBus.SRAM_OE_N = 1'b0; tbDqEn = 1'b0;
         end
         CMD_BAD: begin
            sramBus.SRAM_CE_N = 1'b0; sramBus.SRAM_WE_N = 1'b0;
            sramBus.SRAM_OE_N = 1'b0; tbDqEn = 1'b1;
         end
         default: begin
            sramBus.SRAM_CE_N = 1'b1; sramBus.SRAM_WE_N = 1'b1;
            sramBus.SRAM_OE_N = 1'b1; tbDqEn = 1'b0;
         end
      endcase
      @(posedge clk);
      #2;
   endtask

   task automatic idleCycles(input int n);
      for (int i = 0; i < n; i++) begin
         applyStimulus(CMD_NOP, 18'h0, 16'h0, 1'b1, 1'b1);
      end
   endtask

   // Transaction-level model: memory as a sparse map, a read described only
   // by how many consecutive edges it has been held at one address.
   logic [15:0] modelMem [int];
   int          runLen;
   int          runAddr;
   int          mAddr;
   bit          mWr;
   bit          mRd;
   logic [15:0] mTmp;
   logic [15:0] heldData;
   logic [15:0] expRd;
   logic [15:0] expWr;
   bit          expErr;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         runLen = 0;
         expRd  = 16'd0;
         expWr  = 16'd0;
         expErr = 1'b0;
      end else begin
         mAddr = int'(sramBus.SRAM_ADDR);
         mWr   = !sramBus.SRAM_CE_N && !sramBus.SRAM_WE_N;
         mRd   = !sramBus.SRAM_CE_N && sramBus.SRAM_WE_N && !sramBus.SRAM_OE_N;
         if (!sramBus.SRAM_CE_N && !sramBus.SRAM_WE_N && !sramBus.SRAM_OE_N) expErr = 1'b1;
         if ((mWr || mRd) && sramBus.SRAM_UB_N && sramBus.SRAM_LB_N) expErr = 1'b1;
         if (mWr) begin
            mTmp = modelMem.exists(mAddr) ? modelMem[mAddr] : 16'hxxxx;
            if (!sramBus.SRAM_UB_N) mTmp[15:8] = tbDqOut[15:8];
            if (!sramBus.SRAM_LB_N) mTmp[7:0]  = tbDqOut[7:0];
            modelMem[mAddr] = mTmp;
            expWr  = expWr + 16'd1;
            runLen = 0;
         end else if (mRd) begin
            if (runLen > 0 && mAddr == runAddr) begin
               runLen++;
            end else begin
               runAddr = mAddr;
               runLen  = 1;
            end
            if (runLen == LAT) begin
               expRd    = expRd + 16'd1;
               heldData = modelMem.exists(mAddr) ? modelMem[mAddr] : 16'hxxxx;
            end
         end else begin
            runLen = 0;
         end
      end
   end

   // Compare process: every falling edge outside reset. DQ is only judged
   // while the bench itself is not driving the bus.
   logic [15:0] expDq;

   always @(negedge clk) begin
      if (rst === 1'b1) begin
         checkOutput("rd_count", 32'(rdCount), 32'(expRd));
         checkOutput("wr_count", 32'(wrCount), 32'(expWr));
         checkOutput("busy", 32'(busy), 32'(runLen > 0));
         checkOutput("proto_err", 32'(protoErr), 32'(expErr));
         if (!tbDqEn) begin
            expDq = 16'h0000;
            if (runLen >= LAT && !sramBus.SRAM_UB_N) expDq[15:8] = heldData[15:8];
            if (runLen >= LAT && !sramBus.SRAM_LB_N) expDq[7:0]  = heldData[7:0];
            checkOutput("dq", 32'(normDq(SRAM_DQ)), 32'(expDq));
         end
      end
   end

   // Directed sequence with literal expectations.
   initial begin
      rst               = 1'b0;
      tbDqEn            = 1'b0;
      tbDqOut           = 16'h0;
      sramBus.SRAM_ADDR = 18'h0;
      sramBus.SRAM_UB_N = 1'b1;
      sramBus.SRAM_LB_N = 1'b1;
      sramBus.SRAM_WE_N = 1'b1;
      sramBus.SRAM_CE_N = 1'b1;
      sramBus.SRAM_OE_N = 1'b1;
      repeat (3) @(posedge clk);
      #2;
      checkOutput("reset rd_count", 32'(rdCount), 32'd0);
      checkOutput("reset wr_count", 32'(wrCount), 32'd0);
      checkOutput("reset busy", 32'(busy), 32'd0);
      checkOutput("reset proto_err", 32'(protoErr), 32'd0);
      rst = 1'b1;
      idleCycles(1);

      $display("[TB] full write then read");
      applyStimulus(CMD_WR, 18'h00123, 16'hBEEF, 1'b0, 1'b0);
      checkOutput("wr_count after write", 32'(wrCount), 32'd1);
      applyStimulus(CMD_RD, 18'h00123, 16'h0, 1'b0, 1'b0);
      checkOutput("busy during wait", 32'(busy), 32'd1);
      checkOutput("dq released during wait", 32'(normDq(SRAM_DQ)), 32'h0000);
      applyStimulus(CMD_RD, 18'h00123, 16'h0, 1'b0, 1'b0);
      checkOutput("read BEEF", 32'(normDq(SRAM_DQ)), 32'hBEEF);
      checkOutput("rd_count after read", 32'(rdCount), 32'd1);
      idleCycles(1);

      $display("[TB] byte masks");
      applyStimulus(CMD_WR, 18'h00005, 16'h1234, 1'b0, 1'b0);
      applyStimulus(CMD_WR, 18'h00005, 16'hAAFF, 1'b0, 1'b1);
      applyStimulus(CMD_RD, 18'h00005, 16'h0, 1'b0, 1'b0);
      applyStimulus(CMD_RD, 18'h00005, 16'h0, 1'b0, 1'b0);
      checkOutput("read AA34", 32'(normDq(SRAM_DQ)), 32'hAA34);
      applyStimulus(CMD_RD, 18'h00005, 16'h0, 1'b1, 1'b0);
      checkOutput("read high lane masked", 32'(normDq(SRAM_DQ)), 32'h0034);
      idleCycles(1);

      $display("[TB] back-to-back reads across the top address");
      applyStimulus(CMD_WR, 18'h3FFFF, 16'h5A5A, 1'b0, 1'b0);
      applyStimulus(CMD_WR, 18'h00000, 16'hC3C3, 1'b0, 1'b0);
      checkOutput("wr_count after five writes", 32'(wrCount), 32'd5);
      applyStimulus(CMD_RD, 18'h3FFFF, 16'h0, 1'b0, 1'b0);
      applyStimulus(CMD_RD, 18'h3FFFF, 16'h0, 1'b0, 1'b0);
      checkOutput("read 3FFFF", 32'(normDq(SRAM_DQ)), 32'h5A5A);
      applyStimulus(CMD_RD, 18'h00000, 16'h0, 1'b0, 1'b0);
      checkOutput("dq released after switch", 32'(normDq(SRAM_DQ)), 32'h0000);
      applyStimulus(CMD_RD, 18'h00000, 16'h0, 1'b0, 1'b0);
      checkOutput("read 00000", 32'(normDq(SRAM_DQ)), 32'hC3C3);
      checkOutput("rd_count after back-to-back", 32'(rdCount), 32'd4);
      idleCycles(1);

      $display("[TB] abort and restart");
      applyStimulus(CMD_WR, 18'h00040, 16'h1111, 1'b0, 1'b0);
      applyStimulus(CMD_WR, 18'h00041, 16'h2222, 1'b0, 1'b0);
      applyStimulus(CMD_RD, 18'h00040, 16'h0, 1'b0, 1'b0);
      applyStimulus(CMD_RD, 18'h00041, 16'h0, 1'b0, 1'b0);
      checkOutput("dq released after restart", 32'(normDq(SRAM_DQ)), 32'h0000);
      checkOutput("rd_count not bumped by restart", 32'(rdCount), 32'd4);
      applyStimulus(CMD_RD, 18'h00041, 16'h0, 1'b0, 1'b0);
      checkOutput("read 00041", 32'(normDq(SRAM_DQ)), 32'h2222);
      checkOutput("rd_count after restart", 32'(rdCount), 32'd5);
      applyStimulus(CMD_WR, 18'h00041, 16'h2222, 1'b0, 1'b0);
      tbDqEn = 1'b0;
      #1;
      checkOutput("dq released by write", 32'(normDq(SRAM_DQ)), 32'h0000);
      checkOutput("busy cleared by write", 32'(busy), 32'd0);
      tbDqEn = 1'b1;
      applyStimulus(CMD_RD, 18'h00041, 16'h0, 1'b0, 1'b0);
      applyStimulus(CMD_RD, 18'h00041, 16'h0, 1'b0, 1'b0);
      applyStimulus(CMD_WR, 18'h00041, 16'h7777, 1'b0, 1'b0);
      applyStimulus(CMD_RD, 18'h00041, 16'h0, 1'b0, 1'b0);
      applyStimulus(CMD_RD, 18'h00041, 16'h0, 1'b0, 1'b0);
      checkOutput("read after rewrite", 32'(normDq(SRAM_DQ)), 32'h7777);
      idleCycles(1);

      $display("[TB] protocol errors");
      checkOutput("proto_err before violation", 32'(protoErr), 32'd0);
      applyStimulus(CMD_BAD, 18'h00100, 16'h0F0F, 1'b0, 1'b0);
      checkOutput("proto_err after contention", 32'(protoErr), 32'd1);
      idleCycles(1);
      applyStimulus(CMD_RD, 18'h00123, 16'h0, 1'b0, 1'b0);
      applyStimulus(CMD_RD, 18'h00123, 16'h0, 1'b0, 1'b0);
      checkOutput("read BEEF again", 32'(normDq(SRAM_DQ)), 32'hBEEF);
      checkOutput("proto_err sticky", 32'(protoErr), 32'd1);
      idleCycles(1);
      applyStimulus(CMD_WR, 18'h00005, 16'hFFFF, 1'b1, 1'b1);
      checkOutput("wr_count after null write", 32'(wrCount), 32'd11);
      idleCycles(1);
      applyStimulus(CMD_RD, 18'h00005, 16'h0, 1'b0, 1'b0);
      applyStimulus(CMD_RD, 18'h00005, 16'h0, 1'b0, 1'b0);
      checkOutput("null write left memory", 32'(normDq(SRAM_DQ)), 32'hAA34);
      idleCycles(1);

      $display("[TB] reset during a read");
      applyStimulus(CMD_WR, 18'h00010, 16'h6161, 1'b0, 1'b0);
      applyStimulus(CMD_RD, 18'h00010, 16'h0, 1'b0, 1'b0);
      checkOutput("busy before reset", 32'(busy), 32'd1);
      rst = 1'b0;
      #1;
      checkOutput("busy in reset", 32'(busy), 32'd0);
      checkOutput("rd_count in reset", 32'(rdCount), 32'd0);
      checkOutput("wr_count in reset", 32'(wrCount), 32'd0);
      checkOutput("proto_err in reset", 32'(protoErr), 32'd0);
      checkOutput("dq in reset", 32'(normDq(SRAM_DQ)), 32'h0000);
      idleCycles(2);
      rst = 1'b1;
      idleCycles(1);
      applyStimulus(CMD_RD, 18'h00010, 16'h0, 1'b0, 1'b0);
      checkOutput("dq released after reset read start", 32'(normDq(SRAM_DQ)), 32'h0000);
      applyStimulus(CMD_RD, 18'h00010, 16'h0, 1'b0, 1'b0);
      checkOutput("read after reset", 32'(normDq(SRAM_DQ)), 32'h6161);
      checkOutput("rd_count after reset read", 32'(rdCount), 32'd1);
      idleCycles(2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
